coord_scanner: RTL
==================

# coord_scanner

Parametrised, self-sequencing successor to the pixel-to-complex-plane mapper. It walks a full H_PIXELS x V_PIXELS raster on its own and emits one (a, b) complex-plane coordinate per pixel over a valid/ready stream into the Mandelbrot iteration engine. It replaces per-pixel multiplies with exact incremental accumulation, so results are bit-identical to origin + index*delta modulo 2^DATA_W. Configuration is latched at frame start, so the host can rewrite pan/zoom registers mid-frame without tearing.

## Interface
Parameters:
- DATA_W, 32: fixed-point coordinate width, two's complement.
- CNT_W, 10: pixel counter width.
- H_PIXELS, 640: pixels per line, 1..2^CNT_W.
- V_PIXELS, 480: lines per frame, 1..2^CNT_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame request; ignored unless idle.
- abort  in  1  terminate the current frame.
- delta_x  in  DATA_W  signed real step per pixel.
- delta_y  in  DATA_W  signed imaginary step per line.
- re_origin  in  DATA_W  real coordinate of pixel (0, y).
- im_origin  in  DATA_W  imaginary coordinate of line 0.
- out_valid  out  1  a, b, x, y, sol and eof are valid.
- out_ready  in  1  downstream accepts the beat.
- a  out  DATA_W  real coordinate.
- b  out  DATA_W  imaginary coordinate.
- x  out  CNT_W  pixel column.
- y  out  CNT_W  pixel row.
- sol  out  1  beat is the first pixel of a line (x == 0).
- eof  out  1  beat is the last pixel of the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE and RUN.
- IDLE:
  - out_valid = 0, busy = 0.
  - On start with abort low: latch delta_x, delta_y, re_origin and im_origin into shadow registers.
  - Load a = re_origin, b = im_origin, x = 0, y = 0, then go to RUN.
- RUN:
  - out_valid = 1, busy = 1.
  - Outputs advance only on a handshake (out_valid && out_ready).
  - Without a handshake, a, b, x, y, sol and eof hold stable.
- Advance on handshake:
  - If x < H_PIXELS-1: x += 1, a += shadow delta_x.
  - Otherwise: x = 0, a = shadow re_origin, then:
    - If y < V_PIXELS-1: y += 1, b += shadow delta_y.
    - Otherwise (last pixel): go to IDLE and pulse frame_done next cycle.
- Flags:
  - sol = (x == 0).
  - eof = (x == H_PIXELS-1) && (y == V_PIXELS-1).
- Arithmetic:
  - Additions are DATA_W-bit, modulo 2^DATA_W, with no saturation and no overflow flag.
  - Invariant: a == re_origin + x*delta_x and b == im_origin + y*delta_y, both mod 2^DATA_W.
- Live config inputs are sampled only at start. Changes during RUN have no effect.
- start during RUN is ignored. It is not queued.
- abort:
  - In RUN, abort has priority over any handshake that cycle; the beat is dropped.
  - Next cycle: IDLE, out_valid = 0, frame_done not pulsed.
  - In IDLE, abort together with start means abort wins and the frame does not start.
- H_PIXELS = 1 or V_PIXELS = 1 degenerate cases follow the same rules. A 1x1 frame is a single beat with sol = eof = 1.

## Timing
- Reset values: out_valid 0, busy 0, frame_done 0, a 0, b 0, x 0, y 0, sol 1, eof 0; state IDLE.
- Reset asserted mid-frame clears everything immediately (asynchronous). No frame_done is produced.
- Latency: start sampled at edge T gives out_valid = 1 with pixel (0,0) after edge T, i.e. in cycle T+1.
- Throughput: one beat per cycle while out_ready is held high. A full frame occupies H_PIXELS*V_PIXELS consecutive RUN cycles.
- Frame completion, with the last handshake at cycle N:
  - In cycle N+1: out_valid = 0, busy = 0, frame_done = 1.
  - start in cycle N+1 is accepted, giving a first beat at N+2 (one bubble between frames).
- All outputs are registered. There is no combinational path from out_ready to out_valid.

## Test plan
- Basic frame: H=4, V=3, re_origin=0x100, im_origin=0x200, delta_x=0x10, delta_y=0x20, out_ready=1.
  - Expect 12 consecutive beats; row 2 a = 0x100, 0x110, 0x120, 0x130 with b = 0x240.
  - sol on x=0, eof only on (3,2), frame_done at beat12+1.
- Backpressure: toggle out_ready pseudo-randomly.
  - Outputs hold while out_valid && !out_ready; the accepted-beat sequence is identical to the basic case; no beat is lost or duplicated.
- Wrap and sign: delta_x = 0xFFFFFFF0 (−16), re_origin = 0x8.
  - a sequence is 0x8, 0xFFFFFFF8, 0xFFFFFFE8, 0xFFFFFFD8, each matching the multiply reference mod 2^32.
- Config isolation: change all four config inputs and pulse start at beat 5.
  - Remaining beats still use the latched values; the extra start is ignored; frame_done fires once.
- Abort: assert abort with out_ready=1 at beat 7.
  - Beat 7 is not accepted; next cycle out_valid = 0 and busy = 0 with no frame_done.
  - A following start produces beat (0,0) with the new config.
- Reset mid-frame: drop rst at beat 4.
  - All outputs go to reset values immediately. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/coord_scanner.sv
// Raster walker that emits one (a, b) complex-plane coordinate per pixel over a valid/ready
// stream, using exact incremental accumulation from configuration latched at frame start.
module coord_scanner #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] delta_x,
  input  logic [DATA_W-1:0] delta_y,
  input  logic [DATA_W-1:0] re_origin,
  input  logic [DATA_W-1:0] im_origin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              sol,
  output logic              eof,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] XLast = CNT_W'(H_PIXELS - 1);
  localparam logic [CNT_W-1:0] YLast = CNT_W'(V_PIXELS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] dx_q, dx_d, dy_q, dy_d, re_q, re_d;
  logic              fd_q, fd_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    re_d    = re_q;
    fd_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          dx_d    = delta_x;
          dy_d    = delta_y;
          re_d    = re_origin;
          a_d     = re_origin;
          b_d     = im_origin;
          x_d     = '0;
          y_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Abort outranks the handshake: the presented beat is dropped.
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (x_q != XLast) begin
            x_d = x_q + CNT_W'(1);
            a_d = a_q + dx_q;
          end else begin
            x_d = '0;
            a_d = re_q;
            if (y_q != YLast) begin
              y_d = y_q + CNT_W'(1);
              b_d = b_q + dy_q;
            end else begin
              state_d = StIdle;
              fd_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      re_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      re_q    <= re_d;
      fd_q    <= fd_d;
    end
  end

  assign out_valid  = (state_q == StRun);
  assign busy       = (state_q == StRun);
  assign a          = a_q;
  assign b          = b_q;
  assign x          = x_q;
  assign y          = y_q;
  assign sol        = (x_q == '0);
  assign eof        = out_valid && (x_q == XLast) && (y_q == YLast);
  assign frame_done = fd_q;

endmodule
